// File: rtl/button_conditioner_if.sv
// button_conditioner_if
// Bundles the per-channel button signals of button_conditioner.
//   I      : raw asynchronous button inputs, active-high (master drives)
//   mode   : strobe event select, 00 press, 01 release, 10 press|release,
//            11 press|repeat (master drives)
//   level  : debounced registered level (slave drives)
//   press  : one-cycle pulse on filtered 0->1 (slave drives)
//   rel    : one-cycle pulse on filtered 1->0, the release event
//            ("release" itself is a reserved word) (slave drives)
//   rep    : one-cycle auto-repeat pulse (slave drives)
//   Y      : one-cycle event strobe chosen by mode (slave drives)
interface button_conditioner_if #(
  parameter int CHANNELS = 5
);
  logic [CHANNELS-1:0] I;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] rel;
  logic [CHANNELS-1:0] rep;
  logic [CHANNELS-1:0] Y;

  modport master (
    output I, mode,
    input  level, press, rel, rep, Y
  );

  modport slave (
    input  I, mode,
    output level, press, rel, rep, Y
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
// Multi-channel pushbutton front end. Each channel synchronises its raw
// input, debounces it with a consecutive-sample counter, produces one-cycle
// press/release pulses and optional typematic auto-repeat pulses, and
// drives a strobe Y whose source events are selected by the shared mode.
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : button_conditioner_if slave modport (I, mode in; level, press,
//         rel, rep, Y out). All outputs are registered.
module button_conditioner #(
  parameter int CHANNELS        = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input logic clk,
  input logic rst,
  button_conditioner_if.slave bus
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW = (RMAX > 1) ? $clog2(RMAX) : 1;

  // Elaboration-time guard against parameter values the logic cannot honour.
  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 0 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_conditioner: illegal parameter value");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] syncQ;
    logic [DCW-1:0]         dcnt;
    logic                   s;
    logic                   levelQ;
    logic                   pressQ;
    logic                   relQ;
    logic                   repQ;
    logic                   yQ;
    logic                   rise;
    logic                   fall;
    logic                   repNext;

    assign s = syncQ[SYNC_STAGES-1];

    // A filtered transition happens on the edge where the mismatch run
    // reaches its final sample; these same terms feed the pulse registers.
    assign rise = !levelQ &&  s && (dcnt == DLAST);
    assign fall =  levelQ && !s && (dcnt == DLAST);

    // Synchroniser, debounce filter and all registered channel outputs.
    // Any matching sample clears the counter, so only an unbroken run of
    // DEBOUNCE_CYCLES mismatching samples moves the filtered level.
    always_ff @(posedge clk) begin
      if (rst) begin
        syncQ  <= '0;
        dcnt   <= '0;
        levelQ <= 1'b0;
        pressQ <= 1'b0;
        relQ   <= 1'b0;
        repQ   <= 1'b0;
        yQ     <= 1'b0;
      end else begin
        syncQ  <= {syncQ[SYNC_STAGES-2:0], bus.I[i]};
        pressQ <= rise;
        relQ   <= fall;
        repQ   <= repNext;
        if (s == levelQ) begin
          dcnt <= '0;
        end else if (dcnt == DLAST) begin
          levelQ <= s;
          dcnt   <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        case (bus.mode)
          2'b00:   yQ <= rise;
          2'b01:   yQ <= fall;
          2'b10:   yQ <= rise | fall;
          default: yQ <= rise | repNext;
        endcase
      end
    end

    if (REPEAT_DELAY > 0) begin : g_rep
      localparam logic [RCW-1:0] DLY_LAST = RCW'(REPEAT_DELAY - 1);
      localparam logic [RCW-1:0] PER_LAST = RCW'(REPEAT_PERIOD - 1);
      logic [RCW-1:0] rcnt;
      logic           repeating;

      // rcnt holds (edges since press or since last repeat) minus one, so
      // it is compared against the initial delay until the first repeat and
      // against the period afterwards. The release edge itself never fires.
      assign repNext = levelQ && !fall &&
                       (rcnt == (repeating ? PER_LAST : DLY_LAST));

      // Repeat timer: held clear while the filtered level is low (which
      // covers the press edge) and cleared on the release edge; reloads
      // after every repeat and saturates rather than wrapping.
      always_ff @(posedge clk) begin
        if (rst) begin
          rcnt      <= '0;
          repeating <= 1'b0;
        end else if (!levelQ || fall) begin
          rcnt      <= '0;
          repeating <= 1'b0;
        end else if (repNext) begin
          rcnt      <= '0;
          repeating <= 1'b1;
        end else if (rcnt != '1) begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end else begin : g_norep
      assign repNext = 1'b0;
    end

    assign bus.level[i] = levelQ;
    assign bus.press[i] = pressQ;
    assign bus.rel[i]   = relQ;
    assign bus.rep[i]   = repQ;
    assign bus.Y[i]     = yQ;
  end

endmodule
